// File: rtl/and_gate_tester.sv
// Stimulus driver and checker for a registered 2-input AND gate.
// Ports: clk/rst, start, s_in <- gate, a_out/b_out -> gate, busy, done,
//   pass, err_cnt, fail_mask.
module and_gate_tester #(
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       fail_mask
);

  typedef enum logic {
    IDLE,
    DRIVE
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t           r_state;
  logic [1:0]       r_vec;
  logic [7:0]       r_hold;
  logic             r_a;
  logic             r_b;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic [3:0]       r_mask;

  state_t           w_state;
  logic [1:0]       w_vec;
  logic [7:0]       w_hold;
  logic             w_a;
  logic             w_b;
  logic             w_busy;
  logic             w_done;
  logic             w_pass;
  logic [ERR_W-1:0] w_err;
  logic [3:0]       w_mask;
  logic             w_mis;

  // The gate output is compared against the vector currently applied.
  assign w_mis = s_in != (r_a & r_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_vec   <= '0;
      r_hold  <= '0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_mask  <= '0;
    end else begin
      r_state <= w_state;
      r_vec   <= w_vec;
      r_hold  <= w_hold;
      r_a     <= w_a;
      r_b     <= w_b;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_pass  <= w_pass;
      r_err   <= w_err;
      r_mask  <= w_mask;
    end
  end

  always_comb begin
    w_state = r_state;
    w_vec   = r_vec;
    w_hold  = r_hold;
    w_a     = r_a;
    w_b     = r_b;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_pass  = r_pass;
    w_err   = r_err;
    w_mask  = r_mask;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state = DRIVE;
          w_busy  = 1'b1;
          w_vec   = '0;
          w_hold  = '0;
          w_a     = 1'b0;
          w_b     = 1'b0;
          w_pass  = 1'b0;
          w_err   = '0;
          w_mask  = '0;
        end
      end
      DRIVE: begin
        if (r_hold == HOLD_LAST) begin
          w_hold = '0;
          w_vec  = r_vec + 2'd1;
          if (w_mis) begin
            if (r_err != {ERR_W{1'b1}}) begin
              w_err = r_err + ERR_W'(1);
            end
            w_mask[r_vec] = 1'b1;
          end
          if (r_vec == 2'd3) begin
            w_state = IDLE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_a     = 1'b0;
            w_b     = 1'b0;
            // Verdict must include this last compare.
            w_pass  = (r_err == '0) && !w_mis;
          end else begin
            w_a = w_vec[1];
            w_b = w_vec[0];
          end
        end else begin
          w_hold = r_hold + 8'd1;
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign a_out     = r_a;
  assign b_out     = r_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_cnt   = r_err;
  assign fail_mask = r_mask;

endmodule
